// File: rtl/rib_arbiter.sv
// rib_arbiter: registered three-master arbiter for the rib bus.
//   m0 = load/store unit, m1 = uart_debug, m2 = reserved.
//   Every ownership change passes through a one-cycle DRAIN so registered read
//   data still routes back to the master that issued the last access.
//   An owner that holds the bus for MAX_LOCK cycles while another master waits
//   is released forcibly and masked until the mask no longer matters.
//   MAX_LOCK must be >= 2, and CNT_W must satisfy 2**CNT_W > MAX_LOCK.
// Build option: define RIB_ARB_RR_EN for round-robin selection starting after
//   the previous owner; otherwise selection is fixed priority m1 > m0 > m2.
module rib_arbiter #(
    parameter int MAX_LOCK = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req_i,
    input  logic       m1_req_i,
    input  logic       m2_req_i,
    output logic [2:0] gnt_o,
    output logic [1:0] grant_o,
    output logic       bus_busy_o,
    output logic       rib_hold_flag_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       gnt_reg, gnt_next;
    logic [1:0]       grant_reg, grant_next;
    logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
    logic [2:0]       mask_reg, mask_next;
    logic [1:0]       last_reg, last_next;

    logic [2:0] req;
    logic [2:0] other_unmasked;
    logic [2:0] mask_eff;
    logic [2:0] cand;
    logic [2:0] win;          // {valid, index}
    logic       owner_req;
    logic       other_req;

    assign req = {m2_req_i, m1_req_i, m0_req_i};

    // Mask bits fall away as soon as they stop mattering: when the masked
    // master drops its request, or when nobody else unmasked is asking.
    // Using the cleared view for arbitration in the same cycle means a lone
    // masked requester is granted without an extra idle cycle.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_mask
            assign other_unmasked[gi] = |(req & ~mask_reg & ~(3'b001 << gi));
            assign mask_eff[gi]       = mask_reg[gi] & req[gi] & other_unmasked[gi];
            assign cand[gi]           = req[gi] & ~mask_eff[gi];
        end
    endgenerate

    // First requester in the order a, b, d wins; result is {valid, index}.
    function automatic logic [2:0] pick3(input logic [2:0] c,
                                         input logic [1:0] a,
                                         input logic [1:0] b,
                                         input logic [1:0] d);
        logic [2:0] r;
        r = 3'b000;
        if (c[d]) r = {1'b1, d};
        if (c[b]) r = {1'b1, b};
        if (c[a]) r = {1'b1, a};
        return r;
    endfunction

`ifdef RIB_ARB_RR_EN
    logic [1:0] rr_start;

    // Round-robin: scan 0,1,2,0... starting one past the previous owner.
    always_comb begin
        rr_start = (last_reg == 2'd2) ? 2'd0 : last_reg + 2'd1;
        case (rr_start)
            2'd0:    win = pick3(cand, 2'd0, 2'd1, 2'd2);
            2'd1:    win = pick3(cand, 2'd1, 2'd2, 2'd0);
            default: win = pick3(cand, 2'd2, 2'd0, 2'd1);
        endcase
    end
`else
    // The previous-owner register only steers round-robin builds.
    logic last_unused;
    assign last_unused = ^last_reg;

    // Fixed priority: debug port first, then the LSU, then the reserved port.
    always_comb begin
        win = pick3(cand, 2'd1, 2'd0, 2'd2);
    end
`endif

    // In BUSY the one-hot grant register identifies the owner.
    assign owner_req = |(req & gnt_reg);
    assign other_req = |(req & ~gnt_reg);

    // Next-state and next-register logic for the ownership sequence.
    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        grant_next    = grant_reg;
        lock_cnt_next = lock_cnt_reg;
        mask_next     = mask_eff;
        last_next     = last_reg;

        case (state_reg)
            IDLE: begin
                gnt_next = 3'b000;
                if (win[2]) begin
                    state_next    = BUSY;
                    gnt_next      = 3'b001 << win[1:0];
                    grant_next    = win[1:0];
                    lock_cnt_next = '0;
                    last_next     = win[1:0];
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    state_next = DRAIN;
                    gnt_next   = 3'b000;
                end else if (other_req && lock_cnt_reg == CNT_W'(MAX_LOCK - 1)) begin
                    state_next    = DRAIN;
                    gnt_next      = 3'b000;
                    mask_next     = mask_eff | gnt_reg;
                    lock_cnt_next = '0;
                end else if (other_req) begin
                    if (lock_cnt_reg != CNT_W'(MAX_LOCK))
                        lock_cnt_next = lock_cnt_reg + CNT_W'(1);
                end else begin
                    lock_cnt_next = '0;
                end
            end
            DRAIN: begin
                // grant_o stays put this cycle so in-flight read data returns home.
                gnt_next = 3'b000;
                if (win[2]) begin
                    state_next    = BUSY;
                    gnt_next      = 3'b001 << win[1:0];
                    grant_next    = win[1:0];
                    lock_cnt_next = '0;
                    last_next     = win[1:0];
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 3'b000;
            end
        endcase
    end

    // State and datapath registers; reset clears everything with no drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= 3'b000;
            grant_reg    <= 2'b00;
            lock_cnt_reg <= '0;
            mask_reg     <= 3'b000;
            last_reg     <= 2'b00;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            grant_reg    <= grant_next;
            lock_cnt_reg <= lock_cnt_next;
            mask_reg     <= mask_next;
            last_reg     <= last_next;
        end
    end

    assign gnt_o      = gnt_reg;
    assign grant_o    = grant_reg;
    assign bus_busy_o = (state_reg != IDLE);

    // Core stalls while the LSU waits for the bus or another master owns it.
    // Forced low during reset so the core is not stalled by a reset arbiter.
    assign rib_hold_flag_o = ~rst & ((m0_req_i & ~gnt_reg[0]) |
                                     (bus_busy_o & (grant_reg != 2'b00)));

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: directed scenarios for rib_arbiter with hand-computed
// expected values; inputs change and outputs are sampled 1 ns after posedge.
module tb_rib_arbiter;

    logic       clk;
    logic       rst;
    logic       m0_req_i;
    logic       m1_req_i;
    logic       m2_req_i;
    logic [2:0] gnt_o;
    logic [1:0] grant_o;
    logic       bus_busy_o;
    logic       rib_hold_flag_o;

    int checks;
    int errors;

    rib_arbiter #(.MAX_LOCK(16), .CNT_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .m0_req_i        (m0_req_i),
        .m1_req_i        (m1_req_i),
        .m2_req_i        (m2_req_i),
        .gnt_o           (gnt_o),
        .grant_o         (grant_o),
        .bus_busy_o      (bus_busy_o),
        .rib_hold_flag_o (rib_hold_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; m0_req_i = 1'b1; m1_req_i = 1'b1; m2_req_i = 1'b1;
        step(); step();
        checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", gnt_o); end
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant_o); end
        checks++; if (bus_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus_busy_o); end
        checks++; if (rib_hold_flag_o !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", rib_hold_flag_o); end
        rst = 1'b0;
        #1;
        checks++; if (rib_hold_flag_o !== 1'b1) begin errors++; $display("FAIL reset_hold_after_release got %b want 1", rib_hold_flag_o); end
        checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL reset_gnt_before_edge got %b want 000", gnt_o); end
        step();
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL reset_first_grant got %b want 010", gnt_o); end
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL reset_first_sel got %b want 01", grant_o); end
        m0_req_i = 1'b0; m1_req_i = 1'b0; m2_req_i = 1'b0;
        step();
        checks++; if (gnt_o !== 3'b000 || bus_busy_o !== 1'b1 || grant_o !== 2'b01) begin
            errors++; $display("FAIL reset_drain got gnt=%b busy=%b sel=%b want 000/1/01", gnt_o, bus_busy_o, grant_o);
        end
        step();
        checks++; if (bus_busy_o !== 1'b0 || grant_o !== 2'b01) begin
            errors++; $display("FAIL reset_idle got busy=%b sel=%b want 0/01", bus_busy_o, grant_o);
        end
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single_m0();
        m0_req_i = 1'b1;
        step();
        checks++; if (gnt_o !== 3'b001 || grant_o !== 2'b00 || bus_busy_o !== 1'b1) begin
            errors++; $display("FAIL m0_grant got gnt=%b sel=%b busy=%b want 001/00/1", gnt_o, grant_o, bus_busy_o);
        end
        checks++; if (rib_hold_flag_o !== 1'b0) begin errors++; $display("FAIL m0_hold got %b want 0", rib_hold_flag_o); end
        step(); step();
        checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL m0_keep got %b want 001", gnt_o); end
        m0_req_i = 1'b0;
        step();
        checks++; if (gnt_o !== 3'b000 || bus_busy_o !== 1'b1 || grant_o !== 2'b00) begin
            errors++; $display("FAIL m0_drain got gnt=%b busy=%b sel=%b want 000/1/00", gnt_o, bus_busy_o, grant_o);
        end
        step();
        checks++; if (bus_busy_o !== 1'b0 || grant_o !== 2'b00 || gnt_o !== 3'b000) begin
            errors++; $display("FAIL m0_idle got gnt=%b busy=%b sel=%b want 000/0/00", gnt_o, bus_busy_o, grant_o);
        end
        $display("test_single_m0 done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_contention();
        int bad;
        m0_req_i = 1'b1;
        step();
        checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL cont_m0_grant got %b want 001", gnt_o); end
        m1_req_i = 1'b1;
        // Lock counter reaches MAX_LOCK-1 after 15 edges with m1 waiting.
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (gnt_o !== 3'b001) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL cont_m0_keeps got %0d bad cycles want 0", bad); end
        step();
        checks++; if (gnt_o !== 3'b000 || bus_busy_o !== 1'b1 || grant_o !== 2'b00) begin
            errors++; $display("FAIL cont_forced_drain got gnt=%b busy=%b sel=%b want 000/1/00", gnt_o, bus_busy_o, grant_o);
        end
        checks++; if (rib_hold_flag_o !== 1'b1) begin errors++; $display("FAIL cont_hold_drain got %b want 1", rib_hold_flag_o); end
        step();
        checks++; if (gnt_o !== 3'b010 || grant_o !== 2'b01) begin
            errors++; $display("FAIL cont_m1_grant got gnt=%b sel=%b want 010/01", gnt_o, grant_o);
        end
        checks++; if (rib_hold_flag_o !== 1'b1) begin errors++; $display("FAIL cont_hold_m1 got %b want 1", rib_hold_flag_o); end
        step(); step(); step();
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL cont_m1_keep got %b want 010", gnt_o); end
        m1_req_i = 1'b0;
        step();
        checks++; if (gnt_o !== 3'b000 || grant_o !== 2'b01 || bus_busy_o !== 1'b1) begin
            errors++; $display("FAIL cont_m1_drain got gnt=%b sel=%b busy=%b want 000/01/1", gnt_o, grant_o, bus_busy_o);
        end
        step();
        checks++; if (gnt_o !== 3'b001 || grant_o !== 2'b00) begin
            errors++; $display("FAIL cont_m0_regrant got gnt=%b sel=%b want 001/00", gnt_o, grant_o);
        end
        m0_req_i = 1'b0;
        step(); step();
        checks++; if (bus_busy_o !== 1'b0) begin errors++; $display("FAIL cont_idle got busy=%b want 0", bus_busy_o); end
        $display("test_contention done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_lone_hog();
        int bad_gnt;
        int bad_cnt;
        m2_req_i = 1'b1;
        step();
        checks++; if (gnt_o !== 3'b100 || grant_o !== 2'b10) begin
            errors++; $display("FAIL hog_grant got gnt=%b sel=%b want 100/10", gnt_o, grant_o);
        end
        bad_gnt = 0;
        bad_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (gnt_o !== 3'b100) bad_gnt++;
            if (dut.lock_cnt_reg !== 5'd0) bad_cnt++;
        end
        checks++; if (bad_gnt != 0) begin errors++; $display("FAIL hog_gnt got %0d bad cycles want 0", bad_gnt); end
        checks++; if (bad_cnt != 0) begin errors++; $display("FAIL hog_lock_cnt got %0d nonzero cycles want 0", bad_cnt); end
        checks++; if (rib_hold_flag_o !== 1'b1) begin errors++; $display("FAIL hog_hold got %b want 1", rib_hold_flag_o); end
        m2_req_i = 1'b0;
        step();
        checks++; if (gnt_o !== 3'b000 || grant_o !== 2'b10) begin
            errors++; $display("FAIL hog_drain got gnt=%b sel=%b want 000/10", gnt_o, grant_o);
        end
        step();
        $display("test_lone_hog done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp_gnt;
        logic [1:0] exp_sel;
`ifdef RIB_ARB_RR_EN
        exp_gnt = 3'b100; exp_sel = 2'b10;
`else
        exp_gnt = 3'b001; exp_sel = 2'b00;
`endif
        m1_req_i = 1'b1;
        step();
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL sim_m1_grant got %b want 010", gnt_o); end
        step();
        m1_req_i = 1'b0; m0_req_i = 1'b1; m2_req_i = 1'b1;
        step();
        checks++; if (gnt_o !== 3'b000 || bus_busy_o !== 1'b1 || grant_o !== 2'b01) begin
            errors++; $display("FAIL sim_drain got gnt=%b busy=%b sel=%b want 000/1/01", gnt_o, bus_busy_o, grant_o);
        end
        step();
        checks++; if (gnt_o !== exp_gnt || grant_o !== exp_sel) begin
            errors++; $display("FAIL sim_winner got gnt=%b sel=%b want %b/%b", gnt_o, grant_o, exp_gnt, exp_sel);
        end
        m0_req_i = 1'b0; m2_req_i = 1'b0;
        step(); step();
        checks++; if (bus_busy_o !== 1'b0 || gnt_o !== 3'b000) begin
            errors++; $display("FAIL sim_idle got busy=%b gnt=%b want 0/000", bus_busy_o, gnt_o);
        end
        $display("test_simultaneous done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_mid_reset();
        m1_req_i = 1'b1;
        step();
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL mrst_m1_grant got %b want 010", gnt_o); end
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (gnt_o !== 3'b000 || grant_o !== 2'b00 || bus_busy_o !== 1'b0) begin
            errors++; $display("FAIL mrst_async got gnt=%b sel=%b busy=%b want 000/00/0", gnt_o, grant_o, bus_busy_o);
        end
        checks++; if (rib_hold_flag_o !== 1'b0) begin errors++; $display("FAIL mrst_hold got %b want 0", rib_hold_flag_o); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL mrst_no_early_grant got %b want 000", gnt_o); end
        step();
        checks++; if (gnt_o !== 3'b010 || grant_o !== 2'b01) begin
            errors++; $display("FAIL mrst_regrant got gnt=%b sel=%b want 010/01", gnt_o, grant_o);
        end
        m1_req_i = 1'b0;
        step(); step();
        $display("test_mid_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        m0_req_i = 1'b0; m1_req_i = 1'b0; m2_req_i = 1'b0;
        test_reset();
        test_single_m0();
        test_contention();
        test_lone_hog();
        test_simultaneous();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
